// File: rtl/pipe_ex_pkg.sv
// Shared definitions for the exception/interrupt sequencer: ExcCode values and FSM encoding.
package pipe_ex_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } ex_state_e;

endpackage

// File: rtl/int_sync.sv
// SYNC_STAGES-deep synchronizer for the two asynchronous external interrupt lines.
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [SYNC_STAGES-1:0][1:0] chain_q, chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/pipe_ex_ctrl.sv
// Exception/interrupt/ERET sequencer taken at WB: cancels the commit, flushes the pipe,
// writes CP0 and redirects IF through a held request/ack handshake.
module pipe_ex_ctrl
  import pipe_ex_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR    = 32'h0040_0004,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  interrupt,
  input  logic        wb_valid,
  input  logic        ex_wb,
  input  logic [4:0]  ex_code_wb,
  input  logic        eret_wb,
  input  logic        branch_delay_wb,
  input  logic [31:0] pc_wb,
  input  logic        cp0_ie,
  input  logic        cp0_exl,
  input  logic [7:0]  cp0_int_mask,
  input  logic [31:0] cp0_epc,
  input  logic        redirect_ack,
  output logic [7:0]  int_sig,
  output logic        wb_cancel,
  output logic        flush_if_id,
  output logic        flush_id_exe,
  output logic        flush_exe_mem,
  output logic        flush_mem_wb,
  output logic        cp0_ex_we,
  output logic [31:0] cp0_epc_wr,
  output logic [4:0]  cp0_code_wr,
  output logic        cp0_bd_wr,
  output logic        cp0_eret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  ex_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic [1:0]  int_sync_q;
  logic        int_pend, flush_all;
  logic [31:0] epc_calc;

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (interrupt),
    .q     (int_sync_q)
  );

  assign int_sig  = {4'b0, int_sync_q, 2'b0};
  assign int_pend = (|(int_sig & cp0_int_mask)) & cp0_ie & ~cp0_exl;
  assign epc_calc = branch_delay_wb ? pc_wb - 32'd4 : pc_wb;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    wb_cancel      = 1'b0;
    flush_all      = 1'b0;
    cp0_ex_we      = 1'b0;
    cp0_epc_wr     = '0;
    cp0_code_wr    = '0;
    cp0_bd_wr      = 1'b0;
    cp0_eret       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (wb_valid && (int_pend || ex_wb || eret_wb)) begin
          wb_cancel = 1'b1;
          flush_all = 1'b1;
          cnt_d     = 4'(FLUSH_CYCLES - 1);
          // The take cycle already counts as one flush cycle.
          state_d   = (FLUSH_CYCLES > 1) ? FLUSH : REDIRECT;
          if (int_pend || ex_wb) begin
            cp0_ex_we   = 1'b1;
            cp0_epc_wr  = epc_calc;
            cp0_code_wr = int_pend ? EXC_INT : ex_code_wb;
            cp0_bd_wr   = branch_delay_wb;
            target_d    = EX_VECTOR;
          end else begin
            cp0_eret = 1'b1;
            target_d = cp0_epc;
          end
        end
      end
      FLUSH: begin
        flush_all = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign flush_if_id   = flush_all;
  assign flush_id_exe  = flush_all;
  assign flush_exe_mem = flush_all;
  assign flush_mem_wb  = flush_all;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_ex_ctrl.sv
// Directed bench for pipe_ex_ctrl with hand-computed expectations (FLUSH_CYCLES=2, SYNC_STAGES=2).
module tb_pipe_ex_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  interrupt;
  logic        wb_valid, ex_wb, eret_wb, branch_delay_wb;
  logic [4:0]  ex_code_wb;
  logic [31:0] pc_wb, cp0_epc;
  logic        cp0_ie, cp0_exl, redirect_ack;
  logic [7:0]  cp0_int_mask;
  logic [7:0]  int_sig;
  logic        wb_cancel, flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb;
  logic        cp0_ex_we, cp0_bd_wr, cp0_eret, redirect_valid, busy;
  logic [31:0] cp0_epc_wr, redirect_pc;
  logic [4:0]  cp0_code_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ex_ctrl dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .wb_valid(wb_valid), .ex_wb(ex_wb),
    .ex_code_wb(ex_code_wb), .eret_wb(eret_wb), .branch_delay_wb(branch_delay_wb),
    .pc_wb(pc_wb), .cp0_ie(cp0_ie), .cp0_exl(cp0_exl), .cp0_int_mask(cp0_int_mask),
    .cp0_epc(cp0_epc), .redirect_ack(redirect_ack), .int_sig(int_sig),
    .wb_cancel(wb_cancel), .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .flush_exe_mem(flush_exe_mem), .flush_mem_wb(flush_mem_wb), .cp0_ex_we(cp0_ex_we),
    .cp0_epc_wr(cp0_epc_wr), .cp0_code_wr(cp0_code_wr), .cp0_bd_wr(cp0_bd_wr),
    .cp0_eret(cp0_eret), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow a #2.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wb_idle();
    wb_valid = 0; ex_wb = 0; eret_wb = 0; branch_delay_wb = 0;
    ex_code_wb = 0; pc_wb = 0; redirect_ack = 0;
  endtask

  function automatic logic [3:0] flush_vec();
    return {flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb};
  endfunction

  initial begin
    rst = 0; interrupt = 0; cp0_ie = 0; cp0_exl = 0; cp0_int_mask = 0; cp0_epc = 0;
    wb_idle();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_flush", flush_vec(), 0);
    chk("rst_intsig", int_sig, 0);
    cyc(); rst = 1;

    // Overflow exception, delayed ack
    cyc(); wb_valid = 1; ex_wb = 1; ex_code_wb = 5'd12; pc_wb = 32'h0040_0100; #2;
    chk("ov_we", cp0_ex_we, 1);
    chk("ov_epc", cp0_epc_wr, 32'h0040_0100);
    chk("ov_code", cp0_code_wr, 12);
    chk("ov_bd", cp0_bd_wr, 0);
    chk("ov_cancel", wb_cancel, 1);
    chk("ov_flush0", flush_vec(), 4'hF);
    chk("ov_rv0", redirect_valid, 0);
    cyc(); wb_idle(); #2;
    chk("ov_flush1", flush_vec(), 4'hF);
    chk("ov_busy1", busy, 1);
    chk("ov_we1", cp0_ex_we, 0);
    chk("ov_cancel1", wb_cancel, 0);
    chk("ov_rv1", redirect_valid, 0);
    cyc(); #2;
    chk("ov_flush2", flush_vec(), 0);
    chk("ov_rv2", redirect_valid, 1);
    chk("ov_pc2", redirect_pc, 32'h0040_0004);
    cyc(); #2;
    chk("ov_rv3", redirect_valid, 1);
    chk("ov_pc3", redirect_pc, 32'h0040_0004);
    cyc(); redirect_ack = 1; #2;
    chk("ov_rv4", redirect_valid, 1);
    cyc(); redirect_ack = 0; #2;
    chk("ov_rv5", redirect_valid, 0);
    chk("ov_busy5", busy, 0);

    // Delay-slot exception at PC 0: EPC wraps
    cyc(); wb_valid = 1; ex_wb = 1; ex_code_wb = 5'd10; pc_wb = 0; branch_delay_wb = 1; #2;
    chk("bd_epc", cp0_epc_wr, 32'hFFFF_FFFC);
    chk("bd_bd", cp0_bd_wr, 1);
    chk("bd_code", cp0_code_wr, 10);
    cyc(); wb_idle();
    cyc(); redirect_ack = 1; #2;
    chk("bd_rv", redirect_valid, 1);
    cyc(); redirect_ack = 0; #2;
    chk("bd_idle", busy, 0);

    // Interrupt: synchronizer latency, EXL blocking, priority over ex_wb
    cyc(); interrupt = 2'b01; cp0_int_mask = 8'h04; cp0_ie = 1; cp0_exl = 1;
    wb_valid = 1; #2;
    chk("irq_sync0", int_sig, 0);
    cyc(); #2;
    chk("irq_sync1", int_sig, 0);
    cyc(); #2;
    chk("irq_sync2", int_sig, 8'h04);
    chk("irq_exl_we", cp0_ex_we, 0);
    chk("irq_exl_cancel", wb_cancel, 0);
    cyc(); #2;
    chk("irq_exl_busy", busy, 0);
    cp0_exl = 0; ex_wb = 1; ex_code_wb = 5'd12; pc_wb = 32'h0040_0200; #1;
    chk("irq_we", cp0_ex_we, 1);
    chk("irq_code", cp0_code_wr, 0);
    chk("irq_epc", cp0_epc_wr, 32'h0040_0200);
    cyc(); wb_idle(); interrupt = 0; #2;
    chk("irq_busy", busy, 1);
    cyc(); redirect_ack = 1; #2;
    chk("irq_pc", redirect_pc, 32'h0040_0004);
    cyc(); redirect_ack = 0; cp0_ie = 0;
    cyc(); cyc();

    // ERET, with an ex_wb arriving during FLUSH that must be ignored
    cyc(); cp0_epc = 32'h0040_0230; wb_valid = 1; eret_wb = 1; #2;
    chk("eret_pulse", cp0_eret, 1);
    chk("eret_we", cp0_ex_we, 0);
    chk("eret_cancel", wb_cancel, 1);
    cyc(); eret_wb = 0; ex_wb = 1; ex_code_wb = 5'd8; cp0_epc = 32'h1234_5678; #2;
    chk("fl_ign_we", cp0_ex_we, 0);
    chk("fl_ign_eret", cp0_eret, 0);
    chk("fl_ign_flush", flush_vec(), 4'hF);
    cyc(); wb_idle(); #2;
    chk("eret_pc", redirect_pc, 32'h0040_0230);
    cyc(); redirect_ack = 1; #2;
    chk("eret_rv", redirect_valid, 1);
    cyc(); redirect_ack = 0; #2;
    chk("eret_idle", busy, 0);

    // Reset during REDIRECT, then a normal take
    cyc(); wb_valid = 1; ex_wb = 1; ex_code_wb = 5'd9; pc_wb = 32'h0040_0300;
    cyc(); wb_idle();
    cyc(); #2;
    chk("rr_rv_pre", redirect_valid, 1);
    rst = 0; #1;
    chk("rr_rv", redirect_valid, 0);
    chk("rr_busy", busy, 0);
    chk("rr_flush", flush_vec(), 0);
    chk("rr_pc", redirect_pc, 0);
    cyc(); rst = 1;
    cyc(); wb_valid = 1; ex_wb = 1; ex_code_wb = 5'd8; pc_wb = 32'h0040_0400; #2;
    chk("rr_we", cp0_ex_we, 1);
    chk("rr_code", cp0_code_wr, 8);
    cyc(); wb_idle();
    cyc(); redirect_ack = 1; #2;
    chk("rr_rv2", redirect_valid, 1);
    chk("rr_pc2", redirect_pc, 32'h0040_0004);
    cyc(); redirect_ack = 0; #2;
    chk("rr_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
